// File: rtl/addsub_op_sequencer.sv
// Handshaked sequencer around an external combinational add/sub unit: registers the
// operands, captures result and flag, and maintains an accumulator and error counter.
module addsub_op_sequencer #(
    parameter int WIDTH    = 5,
    parameter int ERRW     = 8,
    parameter bit SAT_HOLD = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [2:0]       req_op,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_data,
    output logic             res_err,
    output logic [WIDTH-1:0] acc_q,
    output logic [ERRW-1:0]  err_cnt,
    output logic [WIDTH-1:0] add_a,
    output logic [WIDTH-1:0] add_b,
    output logic             add_sub,
    input  logic [WIDTH-1:0] add_out,
    input  logic             add_c
);
    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

    localparam logic [2:0] OP_ADD    = 3'b000;
    localparam logic [2:0] OP_SUB    = 3'b001;
    localparam logic [2:0] OP_ACCADD = 3'b010;
    localparam logic [2:0] OP_ACCSUB = 3'b011;
    localparam logic [2:0] OP_CLR    = 3'b100;

    localparam logic [ERRW-1:0] ERR_MAX = {ERRW{1'b1}};
    localparam logic [ERRW-1:0] ERR_ONE = {{(ERRW-1){1'b0}}, 1'b1};

    state_t           state_reg, state_next;
    logic [2:0]       op_reg;
    logic [WIDTH-1:0] add_a_reg, add_b_reg;
    logic             add_sub_reg;
    logic [WIDTH-1:0] res_data_reg, acc_reg;
    logic             res_err_reg;
    logic [ERRW-1:0]  err_cnt_reg;

    logic             op_arith, op_acc, op_illegal;
    logic             cap_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (req_valid) state_next = EXEC;
            EXEC:    state_next = DONE;
            DONE:    if (res_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Decode of the op latched at accept; consumed during EXEC.
    always_comb begin
        op_acc     = (op_reg == OP_ACCADD) || (op_reg == OP_ACCSUB);
        op_arith   = (op_reg == OP_ADD) || (op_reg == OP_SUB) || op_acc;
        op_illegal = !op_arith && (op_reg != OP_CLR);
        cap_err    = op_arith ? add_c : op_illegal;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_reg       <= OP_ADD;
            add_a_reg    <= '0;
            add_b_reg    <= '0;
            add_sub_reg  <= 1'b0;
            res_data_reg <= '0;
            res_err_reg  <= 1'b0;
            acc_reg      <= '0;
            err_cnt_reg  <= '0;
        end else begin
            if (state_reg == IDLE && req_valid) begin
                op_reg <= req_op;
                case (req_op)
                    OP_ADD, OP_SUB: begin
                        add_a_reg   <= req_a;
                        add_b_reg   <= req_b;
                        add_sub_reg <= req_op[0];
                    end
                    OP_ACCADD, OP_ACCSUB: begin
                        add_a_reg   <= acc_reg;
                        add_b_reg   <= req_a;
                        add_sub_reg <= req_op[0];
                    end
                    default: ;
                endcase
            end
            if (state_reg == EXEC) begin
                res_data_reg <= op_arith ? add_out : '0;
                res_err_reg  <= cap_err;
                if (op_reg == OP_CLR) begin
                    acc_reg <= '0;
                end else if (op_acc && (!add_c || !SAT_HOLD)) begin
                    acc_reg <= add_out;
                end
                if (cap_err && err_cnt_reg != ERR_MAX) begin
                    err_cnt_reg <= err_cnt_reg + ERR_ONE;
                end
            end
        end
    end

    assign req_ready = (state_reg == IDLE);
    assign res_valid = (state_reg == DONE);
    assign res_data  = res_data_reg;
    assign res_err   = res_err_reg;
    assign acc_q     = acc_reg;
    assign err_cnt   = err_cnt_reg;
    assign add_a     = add_a_reg;
    assign add_b     = add_b_reg;
    assign add_sub   = add_sub_reg;
endmodule

// File: tb/tb_addsub_op_sequencer.sv
// Scoreboard bench for addsub_op_sequencer: directed ops with hand-computed results,
// a parallel SAT_HOLD=0 instance for the wrap-on-overflow accumulator case.
module tb_addsub_op_sequencer;
    localparam int W = 5;
    localparam int E = 8;

    typedef struct packed {
        logic [W-1:0] data;
        logic         err;
        logic [W-1:0] acc;
        logic [E-1:0] cnt;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         req_valid = 1'b0;
    logic [2:0]   req_op = 3'b000;
    logic [W-1:0] req_a = '0, req_b = '0;
    logic         res_ready = 1'b1;

    logic         req_ready, res_valid, res_err, add_sub, add_c;
    logic [W-1:0] res_data, acc_q, add_a, add_b, add_out;
    logic [E-1:0] err_cnt;

    logic         req_ready0, res_valid0, res_err0, add_sub0, add_c0;
    logic [W-1:0] res_data0, acc_q0, add_a0, add_b0, add_out0;
    logic [E-1:0] err_cnt0;

    int   n_checks = 0;
    int   n_fail = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    // Reference adder: carry out on add, borrow out on subtract.
    assign {add_c, add_out}   = add_sub  ? ({1'b0, add_a}  - {1'b0, add_b})  : ({1'b0, add_a}  + {1'b0, add_b});
    assign {add_c0, add_out0} = add_sub0 ? ({1'b0, add_a0} - {1'b0, add_b0}) : ({1'b0, add_a0} + {1'b0, add_b0});

    addsub_op_sequencer #(.WIDTH(W), .ERRW(E), .SAT_HOLD(1'b1)) u_dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_a(req_a), .req_b(req_b), .res_valid(res_valid),
        .res_ready(res_ready), .res_data(res_data), .res_err(res_err), .acc_q(acc_q),
        .err_cnt(err_cnt), .add_a(add_a), .add_b(add_b), .add_sub(add_sub),
        .add_out(add_out), .add_c(add_c)
    );

    addsub_op_sequencer #(.WIDTH(W), .ERRW(E), .SAT_HOLD(1'b0)) u_dut_wrap (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready0),
        .req_op(req_op), .req_a(req_a), .req_b(req_b), .res_valid(res_valid0),
        .res_ready(res_ready), .res_data(res_data0), .res_err(res_err0), .acc_q(acc_q0),
        .err_cnt(err_cnt0), .add_a(add_a0), .add_b(add_b0), .add_sub(add_sub0),
        .add_out(add_out0), .add_c(add_c0)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // Monitor: every result handshake pops one expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && res_valid && res_ready) begin
                n_checks++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_result: got data=%0d err=%0d, expected no result", res_data, res_err);
                end else begin
                    e = sb.pop_front();
                    $display("result data=%0d err=%0d acc=%0d cnt=%0d", res_data, res_err, acc_q, err_cnt);
                    check("res_data", 32'(res_data), 32'(e.data));
                    check("res_err", 32'(res_err), 32'(e.err));
                    check("acc_q", 32'(acc_q), 32'(e.acc));
                    check("err_cnt", 32'(err_cnt), 32'(e.cnt));
                end
            end
        end
    end

    task automatic wait_ready();
        int t = 0;
        @(negedge clk);
        while (!req_ready && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (!req_ready) check("req_ready_timeout", 32'(req_ready), 32'd1);
    endtask

    // Issues one op, checks the accept/latency profile, and queues the expected result.
    task automatic do_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] d, input logic er, input logic [W-1:0] ac, input logic [E-1:0] cn);
        exp_t e;
        wait_ready();
        e = '{data: d, err: er, acc: ac, cnt: cn};
        sb.push_back(e);
        req_valid = 1'b1; req_op = op; req_a = a; req_b = b;
        $display("request op=%0d a=%0d b=%0d", op, a, b);
        @(posedge clk); #1;
        req_valid = 1'b0;
        check("res_valid_edge_n1", 32'(res_valid), 32'd0);
        check("req_ready_exec", 32'(req_ready), 32'd0);
        @(posedge clk); #1;
        check("res_valid_edge_n2", 32'(res_valid), 32'd1);
    endtask

    initial begin
        // Reset state
        #12;
        check("rst_res_valid", 32'(res_valid), 32'd0);
        check("rst_res_data", 32'(res_data), 32'd0);
        check("rst_res_err", 32'(res_err), 32'd0);
        check("rst_acc_q", 32'(acc_q), 32'd0);
        check("rst_err_cnt", 32'(err_cnt), 32'd0);
        check("rst_add_ab", 32'({add_a, add_b, add_sub}), 32'd0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        check("rst_req_ready", 32'(req_ready), 32'd1);

        do_op(3'b000, 5'd3, 5'd4, 5'd7, 1'b0, 5'd0, 8'd0);
        do_op(3'b001, 5'd3, 5'd5, 5'd30, 1'b1, 5'd0, 8'd1);
        do_op(3'b000, 5'd20, 5'd15, 5'd3, 1'b1, 5'd0, 8'd2);
        do_op(3'b100, 5'd9, 5'd9, 5'd0, 1'b0, 5'd0, 8'd2);
        do_op(3'b010, 5'd6, 5'd31, 5'd6, 1'b0, 5'd6, 8'd2);
        do_op(3'b010, 5'd9, 5'd0, 5'd15, 1'b0, 5'd15, 8'd2);
        do_op(3'b011, 5'd4, 5'd0, 5'd11, 1'b0, 5'd11, 8'd2);
        do_op(3'b010, 5'd25, 5'd0, 5'd4, 1'b1, 5'd11, 8'd3);
        check("wrap_acc_q", 32'(acc_q0), 32'd4);

        // Backpressure: result held, second request not consumed until after handshake.
        repeat (2) @(posedge clk);
        #1 res_ready = 1'b0;
        do_op(3'b000, 5'd1, 5'd2, 5'd3, 1'b0, 5'd11, 8'd3);
        @(negedge clk);
        sb.push_back('{data: 5'd7, err: 1'b0, acc: 5'd11, cnt: 8'd3});
        req_valid = 1'b1; req_op = 3'b001; req_a = 5'd9; req_b = 5'd2;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("stall_req_ready", 32'(req_ready), 32'd0);
            check("stall_res_data", 32'(res_data), 32'd3);
        end
        @(posedge clk); #1 res_ready = 1'b1;
        @(posedge clk); #1;
        check("after_hs_req_ready", 32'(req_ready), 32'd1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        check("next_accept", 32'(req_ready), 32'd0);
        @(posedge clk); #1;
        check("next_res_valid", 32'(res_valid), 32'd1);

        do_op(3'b111, 5'd5, 5'd5, 5'd0, 1'b1, 5'd11, 8'd4);

        // Reset during EXEC aborts the op.
        wait_ready();
        req_valid = 1'b1; req_op = 3'b000; req_a = 5'd1; req_b = 5'd1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check("abort_res_valid", 32'(res_valid), 32'd0);
        check("abort_acc_q", 32'(acc_q), 32'd0);
        check("abort_err_cnt", 32'(err_cnt), 32'd0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        check("abort_req_ready", 32'(req_ready), 32'd1);
        repeat (4) begin
            @(posedge clk); #1;
            check("abort_no_result", 32'(res_valid), 32'd0);
        end

        check("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
